sha_block_padder: RTL and testbench

Streaming message padder for the hashing datapath. It accepts a message as a stream of big-endian words and emits complete padded blocks for the compression core: message bytes, one 0x80 byte, zero fill, then the message bit length. It works out the number of blocks per message at run time as the stream arrives, rather than from a fixed input length. It is parametrised for SHA-256 (512-bit block, 64-bit length field) or SHA-512 (1024-bit block, 128-bit length field) and sits between the message source and the block scheduler.

---
 rtl/sha_block_padder_if.sv | 31 +++
 rtl/sha_block_padder.sv | 184 ++++++++++++++++++
 tb/tb_sha_block_padder.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_block_padder_if.sv
// Stream interface for sha_block_padder: message words in, padded blocks out.
// The padder sits on the slave modport and the message source/block sink on master.
interface sha_block_padder_if #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned BLOCK_W = 512,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned WBYTES  = WORD_W / 8;
  localparam int unsigned BYTES_W = $clog2(WBYTES + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_W-1:0]    in_data;
  logic                 in_last;
  logic [BYTES_W-1:0]   in_bytes;
  logic                 out_valid;
  logic                 out_ready;
  logic [BLOCK_W-1:0]   out_block;
  logic                 out_last;
  logic [CNT_W-1:0]     out_blk_idx;

  modport master (
    output in_valid, in_data, in_last, in_bytes, out_ready,
    input  in_ready, out_valid, out_block, out_last, out_blk_idx
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, out_ready,
    output in_ready, out_valid, out_block, out_last, out_blk_idx
  );
endinterface

// File: rtl/sha_block_padder.sv
// Streaming SHA-2 message padder: buffers big-endian words into blocks and appends
// 0x80, zero fill and the bit length, deciding the block count as the stream arrives.
module sha_block_padder #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned BLOCK_W = 512,
  parameter int unsigned LEN_W   = 64,
  parameter int unsigned CNT_W   = 16
) (
  input logic              clk,
  input logic              rst_n,
  sha_block_padder_if.slave bus
);
  localparam int unsigned WBYTES  = WORD_W / 8;
  localparam int unsigned BYTES_W = $clog2(WBYTES + 1);
  localparam int unsigned WPB     = BLOCK_W / WORD_W;
  localparam int unsigned LWORDS  = LEN_W / WORD_W;
  localparam int unsigned IDX_W   = $clog2(WPB);

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WPB - 1);
  localparam logic [IDX_W-1:0]   LEN_IDX  = IDX_W'(WPB - LWORDS);
  localparam logic [BYTES_W-1:0] FULL     = BYTES_W'(WBYTES);
  localparam logic [WORD_W-1:0]  PAD_WORD = {8'h80, {(WORD_W - 8){1'b0}}};
  localparam logic [CNT_W-1:0]   BLK_MAX  = '1;

  typedef enum logic [1:0] {StFill, StPad, StEmit} state_e;

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  wbuf_q [WPB];
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   bitlen_q, bitlen_d;
  logic [CNT_W-1:0]   blk_q, blk_d;
  logic               pad80_pend_q, pad80_pend_d;
  logic               len_fits_q, len_fits_d;
  logic               final_q, final_d;
  logic               seen_last_q, seen_last_d;

  logic               wr_en;
  logic [WORD_W-1:0]  wr_data;
  logic [WORD_W-1:0]  last_word;
  logic [WORD_W-1:0]  len_word;
  logic [BYTES_W-1:0] nbytes;
  logic [BLOCK_W-1:0] block;

  // Final partial word: keep the valid leading bytes, then 0x80, then zeros.
  always_comb begin
    last_word = '0;
    for (int unsigned b = 0; b < WBYTES; b++) begin
      if (BYTES_W'(b) < bus.in_bytes) begin
        last_word[WORD_W-1-8*b -: 8] = bus.in_data[WORD_W-1-8*b -: 8];
      end else if (BYTES_W'(b) == bus.in_bytes) begin
        last_word[WORD_W-1-8*b -: 8] = 8'h80;
      end
    end
  end

  always_comb begin
    len_word = '0;
    for (int unsigned j = 0; j < LWORDS; j++) begin
      if (idx_q == IDX_W'(WPB - LWORDS + j)) begin
        len_word = bitlen_q[LEN_W-1-j*WORD_W -: WORD_W];
      end
    end
  end

  assign nbytes = bus.in_last ? bus.in_bytes : FULL;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bitlen_d     = bitlen_q;
    blk_d        = blk_q;
    pad80_pend_d = pad80_pend_q;
    len_fits_d   = len_fits_q;
    final_d      = final_q;
    seen_last_d  = seen_last_q;
    wr_en        = 1'b0;
    wr_data      = '0;

    case (state_q)
      StFill: begin
        if (bus.in_valid) begin
          wr_en    = 1'b1;
          bitlen_d = bitlen_q + (LEN_W'(nbytes) << 3);
          idx_d    = idx_q + 1'b1;
          if (!bus.in_last) begin
            wr_data = bus.in_data;
            if (idx_q == LAST_IDX) begin
              state_d = StEmit;
              final_d = 1'b0;
            end
          end else begin
            seen_last_d = 1'b1;
            if (bus.in_bytes == FULL) begin
              wr_data      = bus.in_data;
              pad80_pend_d = 1'b1;
            end else begin
              wr_data    = last_word;
              len_fits_d = (idx_q < LEN_IDX);
            end
            state_d = (idx_q == LAST_IDX) ? StEmit : StPad;
            final_d = 1'b0;
          end
        end
      end

      StPad: begin
        wr_en = 1'b1;
        idx_d = idx_q + 1'b1;
        if (pad80_pend_q) begin
          wr_data      = PAD_WORD;
          pad80_pend_d = 1'b0;
          len_fits_d   = (idx_q < LEN_IDX);
        end else if (len_fits_q && (idx_q >= LEN_IDX)) begin
          wr_data = len_word;
        end
        if (idx_q == LAST_IDX) begin
          state_d = StEmit;
          final_d = len_fits_d;
        end
      end

      StEmit: begin
        if (bus.out_ready) begin
          blk_d = (blk_q == BLK_MAX) ? blk_q : blk_q + 1'b1;
          idx_d = '0;
          if (final_q) begin
            state_d      = StFill;
            bitlen_d     = '0;
            blk_d        = '0;
            pad80_pend_d = 1'b0;
            len_fits_d   = 1'b0;
            final_d      = 1'b0;
            seen_last_d  = 1'b0;
          end else if (!seen_last_q) begin
            state_d = StFill;
          end else begin
            // A fresh padding-only block always has room for the length.
            state_d = StPad;
            if (!pad80_pend_q) len_fits_d = 1'b1;
          end
        end
      end

      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFill;
      idx_q        <= '0;
      bitlen_q     <= '0;
      blk_q        <= '0;
      pad80_pend_q <= 1'b0;
      len_fits_q   <= 1'b0;
      final_q      <= 1'b0;
      seen_last_q  <= 1'b0;
      for (int unsigned w = 0; w < WPB; w++) wbuf_q[w] <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      bitlen_q     <= bitlen_d;
      blk_q        <= blk_d;
      pad80_pend_q <= pad80_pend_d;
      len_fits_q   <= len_fits_d;
      final_q      <= final_d;
      seen_last_q  <= seen_last_d;
      if (wr_en) wbuf_q[idx_q] <= wr_data;
    end
  end

  always_comb begin
    block = '0;
    for (int unsigned w = 0; w < WPB; w++) begin
      block[BLOCK_W-1-w*WORD_W -: WORD_W] = wbuf_q[w];
    end
  end

  assign bus.in_ready    = (state_q == StFill);
  assign bus.out_valid   = (state_q == StEmit);
  assign bus.out_block   = block;
  assign bus.out_last    = final_q;
  assign bus.out_blk_idx = blk_q;
endmodule

// File: tb/tb_sha_block_padder.sv
// Scoreboard bench for sha_block_padder in SHA-256 (a) and SHA-512 (b) configurations,
// with a byte-level padding model and random message/backpressure stimulus.
module tb_sha_block_padder;
  logic clk;
  logic rst_n_a, rst_n_b;

  sha_block_padder_if #(.WORD_W(32), .BLOCK_W(512),  .CNT_W(16)) ia ();
  sha_block_padder_if #(.WORD_W(64), .BLOCK_W(1024), .CNT_W(16)) ib ();

  sha_block_padder #(.WORD_W(32), .BLOCK_W(512), .LEN_W(64), .CNT_W(16)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (ia)
  );

  sha_block_padder #(.WORD_W(64), .BLOCK_W(1024), .LEN_W(128), .CNT_W(16)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (ib)
  );

  typedef struct {
    logic [1023:0] blk;
    bit            last;
    int            idx;
  } exp_t;

  exp_t       exp_a[$];
  exp_t       exp_b[$];
  logic [7:0] msg_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  bit         stall_a = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [1023:0] got, input logic [1023:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference: standard SHA-2 padding on a byte array, sliced into blocks.
  task automatic model(input bit m);
    int            bb;
    int            lb;
    int            nb;
    logic [7:0]    p[$];
    logic [127:0]  bits;
    exp_t          e;
    bb = m ? 128 : 64;
    lb = m ? 16 : 8;
    p = msg_q;
    p.push_back(8'h80);
    while ((p.size() % bb) != bb - lb) p.push_back(8'h00);
    bits = 128'(msg_q.size()) << 3;
    for (int k = 0; k < lb; k++) p.push_back(8'(bits >> (8 * (lb - 1 - k))));
    nb = p.size() / bb;
    for (int i = 0; i < nb; i++) begin
      e.blk = '0;
      for (int j = 0; j < bb; j++) e.blk = {e.blk[1015:0], p[i*bb+j]};
      e.last = (i == nb - 1);
      e.idx  = i;
      if (m) exp_b.push_back(e);
      else   exp_a.push_back(e);
    end
  endtask

  function automatic bit rdy(input bit m);
    return m ? ib.in_ready : ia.in_ready;
  endfunction

  function automatic bit ov(input bit m);
    return m ? ib.out_valid : ia.out_valid;
  endfunction

  task automatic put_word(input bit m, input logic [63:0] d, input bit last, input int nb);
    int t;
    if (m) begin
      ib.in_valid = 1'b1; ib.in_data = d; ib.in_last = last; ib.in_bytes = 4'(nb);
    end else begin
      ia.in_valid = 1'b1; ia.in_data = d[31:0]; ia.in_last = last; ia.in_bytes = 3'(nb);
    end
    t = 0;
    forever begin
      @(negedge clk);
      if (rdy(m)) break;
      t++;
      if (t > 500) begin
        n_vec++;
        n_err++;
        $display("FAIL in_ready_timeout: got 0 expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    if (m) ib.in_valid = 1'b0;
    else   ia.in_valid = 1'b0;
  endtask

  // Push the expected blocks, then stream the message; lat >= 0 checks cycles to out_valid.
  task automatic send(input bit m, input int lat);
    int          wb;
    int          len;
    int          nw;
    int          nb;
    int          n;
    bit          last;
    logic [63:0] d;
    wb  = m ? 8 : 4;
    len = msg_q.size();
    nw  = (len == 0) ? 1 : (len + wb - 1) / wb;
    model(m);
    for (int w = 0; w < nw; w++) begin
      d    = '0;
      last = (w == nw - 1);
      nb   = last ? len - w * wb : wb;
      for (int b = 0; b < wb; b++) begin
        d = {d[55:0], (w * wb + b < len) ? msg_q[w*wb+b] : 8'($urandom)};
      end
      if ($urandom_range(3) == 0) begin
        @(posedge clk);
        #1;
      end
      put_word(m, d, last, nb);
    end
    if (lat >= 0) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ov(m) && n < 100);
      check(m ? "latency_b" : "latency_a", 1024'(n), 1024'(lat));
    end
  endtask

  task automatic rand_msg(input int len);
    msg_q.delete();
    repeat (len) msg_q.push_back(8'($urandom));
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 20000 && (exp_a.size() != 0 || exp_b.size() != 0); t++) @(posedge clk);
    check("drain", 1024'(exp_a.size() + exp_b.size()), 1024'(0));
  endtask

  initial begin
    ia.out_ready = 1'b0;
    ib.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ia.out_ready = !stall_a && ($urandom_range(3) != 0);
      ib.out_ready = ($urandom_range(3) != 0);
    end
  end

  exp_t          e_a;
  exp_t          e_b;
  bit            hv_a, hv_b;
  logic [511:0]  held_a;
  logic [1023:0] held_b;

  initial begin
    hv_a = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n_a && ia.out_valid) begin
        check("in_ready_a_in_emit", 1024'(ia.in_ready), 1024'(0));
        if (hv_a) check("hold_stable_a", {512'b0, ia.out_block}, {512'b0, held_a});
        if (ia.out_ready) begin
          hv_a = 1'b0;
          if (exp_a.size() == 0) begin
            check("unexpected_block_a", 1024'(exp_a.size()), 1024'(1));
          end else begin
            e_a = exp_a.pop_front();
            check("block_a", {512'b0, ia.out_block}, e_a.blk);
            check("last_a", 1024'(ia.out_last), 1024'(e_a.last));
            check("blk_idx_a", 1024'(ia.out_blk_idx), 1024'(e_a.idx));
          end
        end else begin
          hv_a   = 1'b1;
          held_a = ia.out_block;
        end
      end else begin
        hv_a = 1'b0;
      end
    end
  end

  initial begin
    hv_b = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n_b && ib.out_valid) begin
        check("in_ready_b_in_emit", 1024'(ib.in_ready), 1024'(0));
        if (hv_b) check("hold_stable_b", ib.out_block, held_b);
        if (ib.out_ready) begin
          hv_b = 1'b0;
          if (exp_b.size() == 0) begin
            check("unexpected_block_b", 1024'(exp_b.size()), 1024'(1));
          end else begin
            e_b = exp_b.pop_front();
            check("block_b", ib.out_block, e_b.blk);
            check("last_b", 1024'(ib.out_last), 1024'(e_b.last));
            check("blk_idx_b", 1024'(ib.out_blk_idx), 1024'(e_b.idx));
          end
        end else begin
          hv_b   = 1'b1;
          held_b = ib.out_block;
        end
      end else begin
        hv_b = 1'b0;
      end
    end
  end

  initial begin
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    ia.in_valid = 1'b0; ia.in_data = '0; ia.in_last = 1'b0; ia.in_bytes = '0;
    ib.in_valid = 1'b0; ib.in_data = '0; ib.in_last = 1'b0; ib.in_bytes = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid_a", 1024'(ia.out_valid), 1024'(0));
    check("rst_in_ready_a", 1024'(ia.in_ready), 1024'(1));
    check("rst_out_block_a", {512'b0, ia.out_block}, 1024'(0));
    check("rst_out_last_a", 1024'(ia.out_last), 1024'(0));
    check("rst_blk_idx_a", 1024'(ia.out_blk_idx), 1024'(0));
    check("rst_out_valid_b", 1024'(ib.out_valid), 1024'(0));
    check("rst_in_ready_b", 1024'(ib.in_ready), 1024'(1));
    @(negedge clk);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    @(posedge clk);
    #1;

    // SHA-256: "abc", empty, 55, 56 bytes.
    msg_q = '{8'h61, 8'h62, 8'h63};
    send(0, 16);
    msg_q.delete();
    send(0, 16);
    rand_msg(55);
    send(0, 3);
    rand_msg(56);
    send(0, -1);

    // 64 bytes with the sink stalled on the first block.
    wait_drain();
    stall_a = 1'b1;
    rand_msg(64);
    send(0, 1);
    repeat (5) @(negedge clk);
    check("stall_out_valid_a", 1024'(ia.out_valid), 1024'(1));
    check("stall_in_ready_a", 1024'(ia.in_ready), 1024'(0));
    stall_a = 1'b0;

    repeat (15) begin
      rand_msg($urandom_range(0, 150));
      send(0, -1);
    end

    // SHA-512: "abc", then a reset while padding, then recovery.
    msg_q = '{8'h61, 8'h62, 8'h63};
    send(1, 16);
    rand_msg(5);
    send(1, -1);
    repeat (3) @(posedge clk);
    #2;
    rst_n_b = 1'b0;
    #1;
    check("midpad_rst_out_valid_b", 1024'(ib.out_valid), 1024'(0));
    check("midpad_rst_in_ready_b", 1024'(ib.in_ready), 1024'(1));
    exp_b.delete();
    @(negedge clk);
    rst_n_b = 1'b1;
    @(posedge clk);
    #1;
    msg_q = '{8'h61, 8'h62, 8'h63};
    send(1, 16);
    repeat (6) begin
      rand_msg($urandom_range(0, 300));
      send(1, -1);
    end

    wait_drain();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
